fft_stage_regbank: RTL and testbench

- Parametrised, single-clock successor of the FFT stage register file.
- Holds one input frame, NSTAGES-1 intermediate stage frames and one output frame.
- Sequences stage selection itself, so no external stage mux select is needed.
- Sits between the frame loader and the MAC array; uses valid/ready handshakes on the frame input and frame output.

---
 rtl/fft_stage_regbank_pkg.sv | 38 +++
 rtl/fft_stage_regbank_if.sv | 48 ++++
 rtl/fft_stage_regbank_frame_reg.sv | 21 ++
 rtl/fft_stage_regbank.sv | 164 ++++++++++++++++
 tb/tb_fft_stage_regbank.sv | 380 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_stage_regbank_pkg.sv
// FFT stage register bank: shared widths, FSM state and sample slice helpers.
// Used by the bank top, its interface and the bench.
package fft_regbank_pkg;

  localparam int DW_DEF   = 16;
  localparam int NPTS_DEF = 16;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  function automatic int frame_w(
    input int dw,
    input int npts
  );
    return 2 * dw * npts;
  endfunction

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int re_lo(
    input int dw,
    input int k
  );
    return 2 * dw * k;
  endfunction

  function automatic int im_lo(
    input int dw,
    input int k
  );
    return 2 * dw * k + dw;
  endfunction

endpackage

// File: rtl/fft_stage_regbank_if.sv
// Frame-in, MAC and frame-out handshakes of the FFT stage register bank.
// master = frame loader / MAC array / sink side, slave = the bank.
interface fft_stage_regbank_if
  import fft_regbank_pkg::*;
#(
  parameter int FW = frame_w(DW_DEF, NPTS_DEF)
);

  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] in_data;

  logic [FW-1:0] mac_in;
  logic          mac_in_valid;
  logic          mac_res_valid;
  logic [FW-1:0] mac_res;

  logic          out_valid;
  logic          out_ready;
  logic [FW-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output mac_res_valid,
    output mac_res,
    output out_ready,
    input  in_ready,
    input  mac_in,
    input  mac_in_valid,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  mac_res_valid,
    input  mac_res,
    input  out_ready,
    output in_ready,
    output mac_in,
    output mac_in_valid,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/fft_stage_regbank_frame_reg.sv
// Frame-wide register with load enable and hold.
// Async active-low reset clears it to zero.
module fft_frame_reg #(
  parameter int W = 512
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fft_stage_regbank.sv
// FFT stage register bank: input, intermediate and output frames plus stage
// sequencing. Define REGBANK_PINGPONG_EN for a second input frame buffer.
module fft_stage_regbank
  import fft_regbank_pkg::*;
#(
  parameter  int DW      = DW_DEF,
  parameter  int NPTS    = NPTS_DEF,
  parameter  int NSTAGES = 4,
  parameter  int SEL_W   = sel_w(NSTAGES),
  localparam int FW      = frame_w(DW, NPTS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             local_clr,
  fft_stage_regbank_if.slave bus,
  output logic [SEL_W-1:0] stage_idx,
  output logic             busy,
  output logic             err_unexp
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(NSTAGES - 1);

  state_t        state;
  logic          out_valid_q;
  logic [FW-1:0] r [NSTAGES];
  logic [FW-1:0] rout;

  logic          at_last;
  logic          stall;
  logic          res_acc;
  logic          last_acc;
  logic          in_acc;
  logic          r0_en;
  logic [FW-1:0] r0_d;
  logic          restart;

  assign at_last  = (stage_idx == LAST);
  assign stall    = at_last && out_valid_q
                 && !bus.out_ready;
  assign bus.mac_in_valid = (state == RUN)
                         && !stall;
  assign bus.mac_in = r[stage_idx];

  // An abort in the same cycle wins over a result
  assign res_acc  = bus.mac_res_valid
                 && bus.mac_in_valid
                 && !local_clr;
  assign last_acc = res_acc && at_last;
  assign in_acc   = bus.in_valid && bus.in_ready;

  assign busy          = (state == RUN);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = rout;

`ifdef REGBANK_PINGPONG_EN
  logic          b_full;
  logic [FW-1:0] r0b;
  logic          b_en;
  logic          b_take;
  logic          direct;

  assign bus.in_ready = !local_clr
                     && ((state == IDLE) || !b_full);
  assign b_take  = last_acc && b_full;
  // A frame offered as the last result lands goes straight to R[0]
  assign direct  = in_acc
                && ((state == IDLE) || last_acc);
  assign b_en    = in_acc && !direct;
  assign r0_en   = direct || b_take;
  assign r0_d    = b_take ? r0b : bus.in_data;
  assign restart = direct || b_take;

  fft_frame_reg #(.W(FW)) u_r0b (
    .clk   (clock),
    .rst_n (reset),
    .en    (b_en),
    .d     (bus.in_data),
    .q     (r0b)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      b_full <= 1'b0;
    end else if (local_clr) begin
      b_full <= 1'b0;
    end else if (b_en) begin
      b_full <= 1'b1;
    end else if (b_take) begin
      b_full <= 1'b0;
    end
  end
`else
  assign bus.in_ready = !local_clr
                     && (state == IDLE);
  assign r0_en   = in_acc;
  assign r0_d    = bus.in_data;
  assign restart = in_acc;
`endif

  fft_frame_reg #(.W(FW)) u_r0 (
    .clk   (clock),
    .rst_n (reset),
    .en    (r0_en),
    .d     (r0_d),
    .q     (r[0])
  );

  for (genvar i = 1; i < NSTAGES; i++) begin : g_stage
    logic en;
    assign en = res_acc
             && (stage_idx == SEL_W'(i - 1));

    fft_frame_reg #(.W(FW)) u_ri (
      .clk   (clock),
      .rst_n (reset),
      .en    (en),
      .d     (bus.mac_res),
      .q     (r[i])
    );
  end

  fft_frame_reg #(.W(FW)) u_rout (
    .clk   (clock),
    .rst_n (reset),
    .en    (last_acc),
    .d     (bus.mac_res),
    .q     (rout)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      stage_idx   <= '0;
      out_valid_q <= 1'b0;
      err_unexp   <= 1'b0;
    end else begin
      if (last_acc) begin
        out_valid_q <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (local_clr) begin
        state     <= IDLE;
        stage_idx <= '0;
        err_unexp <= 1'b0;
      end else begin
        if (bus.mac_res_valid && !bus.mac_in_valid) begin
          err_unexp <= 1'b1;
        end
        if (restart) begin
          state     <= RUN;
          stage_idx <= '0;
        end else if (last_acc) begin
          state     <= IDLE;
          stage_idx <= '0;
        end else if (res_acc) begin
          stage_idx <= stage_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_stage_regbank.sv
// Directed bench for fft_stage_regbank with a frame-level model and MAC stub.
// The MAC stub adds 1 to every real part with a 2-cycle latency.
module tb_fft_stage_regbank;
  import fft_regbank_pkg::*;

  localparam int DW   = 16;
  localparam int NPTS = 16;
  localparam int NS   = 4;
  localparam int SW   = 2;
  localparam int FW   = 2 * DW * NPTS;

  typedef logic [FW-1:0] frame_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          local_clr = 1'b0;
  logic [SW-1:0] stage_idx;
  logic          busy;
  logic          err_unexp;

  fft_stage_regbank_if #(.FW(FW)) bus ();

  fft_stage_regbank #(
    .DW      (DW),
    .NPTS    (NPTS),
    .NSTAGES (NS)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .local_clr (local_clr),
    .bus       (bus),
    .stage_idx (stage_idx),
    .busy      (busy),
    .err_unexp (err_unexp)
  );

  always #5 clock = ~clock;

  int     checks = 0;
  int     errors = 0;
  logic   chk_on = 1'b0;
  frame_t exp_q[$];
  frame_t in_q[$];

  logic   mac_en = 1'b1;
  logic   mac_kill = 1'b0;
  logic   mac_pulse = 1'b0;
  logic   stray_pulse = 1'b0;
  frame_t mac_data = '0;
  frame_t stray_data = '0;
  frame_t mf;
  int     ms;

  assign bus.mac_res_valid = mac_pulse | stray_pulse;
  assign bus.mac_res = stray_pulse ? stray_data : mac_data;

  task automatic chk(
    input string  name,
    input frame_t act,
    input frame_t exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not seen", name);
  endtask

  function automatic frame_t frame_of(
    input int re0,
    input int im0,
    input int ims
  );
    frame_t f;
    f = '0;
    for (int k = 0; k < NPTS; k++) begin
      f[2*DW*k +: DW]    = 16'(re0 + k);
      f[2*DW*k+DW +: DW] = 16'(im0 + ims * k);
    end
    return f;
  endfunction

  function automatic frame_t add_real(
    input frame_t f,
    input int     n
  );
    frame_t g;
    g = f;
    for (int k = 0; k < NPTS; k++) begin
      g[2*DW*k +: DW] = g[2*DW*k +: DW] + 16'(n);
    end
    return g;
  endfunction

  // Frame-level model: each stage adds one, output = input + NS
  initial begin
    forever begin
      @(negedge clock);
      if (chk_on && reset) begin
        if (bus.in_valid && bus.in_ready) begin
          in_q.push_back(bus.in_data);
          exp_q.push_back(add_real(bus.in_data, NS));
        end
        if (bus.mac_in_valid) begin
          if (in_q.size() == 0) miss("mac_in_frame");
          else chk("mac_in", bus.mac_in,
                   add_real(in_q[0], int'(stage_idx)));
        end
        if (bus.out_valid) begin
          if (exp_q.size() == 0) miss("out_frame");
          else begin
            chk("out_data", bus.out_data, exp_q[0]);
            if (bus.out_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // MAC array stub
  initial begin
    forever begin
      @(negedge clock);
      if (mac_en && reset && bus.mac_in_valid) begin
        mf = bus.mac_in;
        ms = int'(stage_idx);
        mac_kill = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        if (!mac_kill) begin
          mac_data  = add_real(mf, 1);
          mac_pulse = 1'b1;
        end
        @(posedge clock);
        #1 mac_pulse = 1'b0;
        if (!mac_kill && ms == NS - 1) begin
          if (in_q.size() > 0) void'(in_q.pop_front());
          @(negedge clock);
          chk("out_latency", bus.out_valid, 1);
        end
      end
    end
  end

  task automatic send(input frame_t f);
    bit ok;
    ok = 0;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b1;
    bus.in_data  = f;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (bus.in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) miss("send");
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (bus.out_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) miss(name);
  endtask

  task automatic wait_stage(input int n);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (busy && int'(stage_idx) == n) begin
        ok = 1;
        break;
      end
    end
    if (!ok) miss("wait_stage");
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (!busy && !bus.out_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) miss("wait_idle");
  endtask

  task automatic chk_reset_outs(input string p);
    chk({p, "_in_ready"}, bus.in_ready, 1);
    chk({p, "_mac_vld"}, bus.mac_in_valid, 0);
    chk({p, "_out_vld"}, bus.out_valid, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_err"}, err_unexp, 0);
    chk({p, "_stage"}, stage_idx, 0);
    chk({p, "_out_data"}, bus.out_data, 0);
    chk({p, "_mac_in"}, bus.mac_in, 0);
  endtask

  frame_t fa, fb, fc, fd, fe;
  int     cnt;
  bit     gap;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk_reset_outs("rst");
    chk_on = 1'b1;

    // Frame A: re=k, im=-k -> out re=k+4
    fa = frame_of(0, 0, -1);
    send(fa);
    @(negedge clock);
    chk("a_first_mac", bus.mac_in_valid, 1);
    chk("a_busy", busy, 1);
    chk("a_in_ready", bus.in_ready, 0);
    wait_out("a_out");
    chk("a_out_lit", bus.out_data,
        frame_of(4, 0, -1));
    wait_idle();

    // Stray result in IDLE
    mac_en = 1'b0;
    @(posedge clock);
    #1;
    stray_data  = frame_of(77, 1, 1);
    stray_pulse = 1'b1;
    @(posedge clock);
    #1 stray_pulse = 1'b0;
    @(negedge clock);
    chk("stray_err", err_unexp, 1);
    chk("stray_r0", bus.mac_in, fa);
    chk("stray_rout", bus.out_data,
        frame_of(4, 0, -1));
    chk("stray_ovld", bus.out_valid, 0);
    @(posedge clock);
    #1 local_clr = 1'b1;
    @(posedge clock);
    #1 local_clr = 1'b0;
    @(negedge clock);
    chk("clr_err", err_unexp, 0);
    mac_en = 1'b1;

    // Output stall
    bus.out_ready = 1'b0;
    fb = frame_of(100, 0, 1);
    send(fb);
    wait_out("b_out");
    fc = frame_of(16'hFFFC, 0, 3);
    send(fc);
    wait_stage(3);
    chk("stall_mac_vld", bus.mac_in_valid, 0);
    chk("stall_ovld", bus.out_valid, 1);
    chk("stall_b", bus.out_data,
        frame_of(104, 0, 1));
    repeat (3) @(negedge clock);
    chk("stall_hold_vld", bus.mac_in_valid, 0);
    chk("stall_hold_b", bus.out_data,
        frame_of(104, 0, 1));
    @(posedge clock);
    #1 bus.out_ready = 1'b1;
    @(negedge clock);
    chk("unstall_mac_vld", bus.mac_in_valid, 1);
    @(negedge clock);
    chk("b_taken", bus.out_valid, 0);
    wait_out("c_out");
    chk("c_out_wrap", bus.out_data,
        frame_of(0, 0, 3));
    wait_idle();

    // local_clr at stage 1, in_valid in the same cycle
    fd = frame_of(5, 9, 2);
    send(fd);
    wait_stage(1);
    @(posedge clock);
    #1;
    local_clr    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = frame_of(1, 1, 1);
    @(negedge clock);
    chk("clr_in_ready", bus.in_ready, 0);
    @(posedge clock);
    #1;
    local_clr    = 1'b0;
    bus.in_valid = 1'b0;
    void'(exp_q.pop_back());
    void'(in_q.pop_front());
    @(negedge clock);
    chk("clr_busy", busy, 0);
    chk("clr_idle_rdy", bus.in_ready, 1);
    chk("clr_ovld", bus.out_valid, 0);
    chk("clr_stage", stage_idx, 0);
    repeat (4) @(negedge clock);
    chk("abort_err", err_unexp, 1);
    @(posedge clock);
    #1 local_clr = 1'b1;
    @(posedge clock);
    #1 local_clr = 1'b0;
    @(negedge clock);
    chk("abort_clr", err_unexp, 0);

    // Recovery with a random frame
    for (int k = 0; k < NPTS; k++) begin
      fe[2*DW*k +: DW]    = 16'($urandom);
      fe[2*DW*k+DW +: DW] = 16'($urandom);
    end
    send(fe);
    wait_out("e_out");
    wait_idle();

`ifdef REGBANK_PINGPONG_EN
    // Back-to-back frames
    send(frame_of(10, 0, 1));
    send(frame_of(20, 5, 1));
    cnt = 0;
    gap = 0;
    for (int i = 0; i < 200 && cnt < 2; i++) begin
      @(negedge clock);
      if (bus.out_valid) cnt++;
      if (cnt < 2 && !busy) gap = 1;
    end
    chk("pp_outs", cnt, 2);
    chk("pp_gap", gap, 0);
    wait_idle();
`endif

    // Asynchronous reset at stage 2
    send(frame_of(3, 3, 3));
    wait_stage(2);
    @(posedge clock);
    #1;
    mac_kill = 1'b1;
    reset    = 1'b0;
    @(negedge clock);
    chk_reset_outs("mid");
    in_q.delete();
    exp_q.delete();
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (4) @(negedge clock);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_rdy", bus.in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
